// File: rtl/systolic_skew_feeder.sv
// Skew feeder for a DIM x DIM systolic array.
// Takes one unskewed A column / B row vector per beat for DIM beats and emits
// diagonally staggered lanes: lane i is delayed i cycles beyond lane 0, so
// operands meet in the correct PE. start/busy/done frame each pass.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             begin a pass (sampled only in IDLE)
//   in_valid/in_ready beat handshake; in_ready is combinational, high in FEED
//   a_in, b_in        DIM lanes of DATA_W bits, lane i at [i*DATA_W +: DATA_W]
//   a_out, b_out      skewed lanes toward array west / north edges
//   out_valid         per-lane valid, bit i qualifies lane i of a_out and b_out
//   busy              high in FEED and DRAIN
//   done              one-cycle pulse in the last DRAIN cycle
module systolic_skew_feeder #(
    parameter int unsigned DIM    = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIM*DATA_W-1:0] a_in,
    input  logic [DIM*DATA_W-1:0] b_in,
    output logic [DIM*DATA_W-1:0] a_out,
    output logic [DIM*DATA_W-1:0] b_out,
    output logic [DIM-1:0]        out_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CNT_W = $clog2(DIM + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               accept_c;

    // Next-state and control: counts accepted beats, then DIM drain cycles.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        accept_c    = (state_q == FEED) && in_valid;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FEED;
                    beat_cnt_d = '0;
                end
            end
            FEED: begin
                if (accept_c) begin
                    if (beat_cnt_q == CNT_W'(DIM - 1)) begin
                        state_d     = DRAIN;
                        beat_cnt_d  = '0;
                        drain_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == CNT_W'(DIM - 1)) begin
                    state_d     = IDLE;
                    drain_cnt_d = '0;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // done lands in the final DRAIN cycle, which is also when lane DIM-1
        // presents the last beat; for DIM=1 that is the cycle after accept.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DRAIN) && (drain_cnt_d == CNT_W'(DIM - 1));
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready = (state_q == FEED);
    assign busy     = busy_q;
    assign done     = done_q;

    // Lane i: shift chain of i+1 stages carrying data and valid. Every cycle
    // the head loads either the accepted beat or a zero bubble, so gaps keep
    // their skew and invalid slots always carry zero data.
    for (genvar i = 0; i < DIM; i++) begin : g_lane
        for (genvar s = 0; s <= i; s++) begin : g_stage
            logic [DATA_W-1:0] a_d, a_q;
            logic [DATA_W-1:0] b_d, b_q;
            logic              v_d, v_q;

            if (s == 0) begin : g_head
                always_comb begin
                    a_d = accept_c ? a_in[i*DATA_W +: DATA_W] : '0;
                    b_d = accept_c ? b_in[i*DATA_W +: DATA_W] : '0;
                    v_d = accept_c;
                end
            end else begin : g_body
                always_comb begin
                    a_d = g_stage[s-1].a_q;
                    b_d = g_stage[s-1].b_q;
                    v_d = g_stage[s-1].v_q;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    v_q <= v_d;
                end
            end
        end

        assign a_out[i*DATA_W +: DATA_W] = g_stage[i].a_q;
        assign b_out[i*DATA_W +: DATA_W] = g_stage[i].b_q;
        assign out_valid[i]              = g_stage[i].v_q;
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a DIM=4 instance driven from a per-cycle
// vector table (inputs for the cycle plus the outputs expected in that same
// cycle), hand sequences for reset mid-pass and back-to-back passes, and a
// DIM=1 instance checked for the no-skew case.
module tb_systolic_skew_feeder;

    typedef struct {
        logic        st;
        logic        iv;
        logic [31:0] a;
        logic [31:0] ea;
        logic [3:0]  ev;
        logic        ed;
        logic        eb;
        logic        er;
    } row_t;

    logic        clk;
    logic        rst;
    logic        start, in_valid, in_ready;
    logic [31:0] a_in, b_in, a_out, b_out;
    logic [3:0]  out_valid;
    logic        busy, done;

    logic        start1, in_valid1, in_ready1;
    logic [7:0]  a_in1, b_in1, a_out1, b_out1;
    logic [0:0]  out_valid1;
    logic        busy1, done1;

    int n_tests;
    int n_fail;
    row_t tbl [23];

    systolic_skew_feeder #(.DIM(4), .DATA_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a_in(a_in), .b_in(b_in), .a_out(a_out),
        .b_out(b_out), .out_valid(out_valid), .busy(busy), .done(done)
    );

    systolic_skew_feeder #(.DIM(1), .DATA_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1),
        .in_ready(in_ready1), .a_in(a_in1), .b_in(b_in1), .a_out(a_out1),
        .b_out(b_out1), .out_valid(out_valid1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic row_t mk(input logic st, input logic iv, input logic [31:0] a,
                                input logic [31:0] ea, input logic [3:0] ev,
                                input logic ed, input logic eb, input logic er);
        row_t r;
        r.st = st; r.iv = iv; r.a = a; r.ea = ea; r.ev = ev;
        r.ed = ed; r.eb = eb; r.er = er;
        return r;
    endfunction

    // b_in is always driven as a_in with bit 7 of each lane set.
    function automatic logic [31:0] exp_b(input logic [31:0] ea, input logic [3:0] ev);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            if (ev[i]) r[i*8 +: 8] = ea[i*8 +: 8] | 8'h80;
        return r;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic apply(input row_t x, input int id);
        @(negedge clk);
        start    = x.st;
        in_valid = x.iv;
        a_in     = x.a;
        b_in     = x.a | 32'h80808080;
        #1;
        chk("a_out", id, a_out, x.ea);
        chk("b_out", id, b_out, exp_b(x.ea, x.ev));
        chk("out_valid", id, 32'(out_valid), 32'(x.ev));
        chk("done", id, 32'(done), 32'(x.ed));
        chk("busy", id, 32'(busy), 32'(x.eb));
        chk("in_ready", id, 32'(in_ready), 32'(x.er));
    endtask

    task automatic apply_range(input int lo, input int hi, input int base);
        for (int r = lo; r <= hi; r++) apply(tbl[r], base + r);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        start = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; in_valid1 = 1'b0; a_in1 = '0; b_in1 = '0;

        // IDLE with in_valid, then basic pass (beats accepted at rows 3..6)
        tbl[0]  = mk(0, 1, 32'h55555555, 32'h00000000, 4'b0000, 0, 0, 0);
        tbl[1]  = mk(0, 0, 32'h00000000, 32'h00000000, 4'b0000, 0, 0, 0);
        tbl[2]  = mk(1, 0, 32'h00000000, 32'h00000000, 4'b0000, 0, 0, 0);
        tbl[3]  = mk(0, 1, 32'h03020100, 32'h00000000, 4'b0000, 0, 1, 1);
        tbl[4]  = mk(1, 1, 32'h13121110, 32'h00000000, 4'b0001, 0, 1, 1);
        tbl[5]  = mk(0, 1, 32'h23222120, 32'h00000110, 4'b0011, 0, 1, 1);
        tbl[6]  = mk(0, 1, 32'h33323130, 32'h00021120, 4'b0111, 0, 1, 1);
        tbl[7]  = mk(1, 0, 32'h00000000, 32'h03122130, 4'b1111, 0, 1, 0);
        tbl[8]  = mk(0, 0, 32'h00000000, 32'h13223100, 4'b1110, 0, 1, 0);
        tbl[9]  = mk(0, 0, 32'h00000000, 32'h23320000, 4'b1100, 0, 1, 0);
        tbl[10] = mk(0, 0, 32'h00000000, 32'h33000000, 4'b1000, 1, 1, 0);
        tbl[11] = mk(0, 0, 32'h00000000, 32'h00000000, 4'b0000, 0, 0, 0);
        // bubble pass: gap at row 15, start pulses at 15 (FEED) and 18 (DRAIN)
        tbl[12] = mk(1, 0, 32'h00000000, 32'h00000000, 4'b0000, 0, 0, 0);
        tbl[13] = mk(0, 1, 32'h03020100, 32'h00000000, 4'b0000, 0, 1, 1);
        tbl[14] = mk(0, 1, 32'h13121110, 32'h00000000, 4'b0001, 0, 1, 1);
        tbl[15] = mk(1, 0, 32'hDEADBEEF, 32'h00000110, 4'b0011, 0, 1, 1);
        tbl[16] = mk(0, 1, 32'h23222120, 32'h00021100, 4'b0110, 0, 1, 1);
        tbl[17] = mk(0, 1, 32'h33323130, 32'h03120020, 4'b1101, 0, 1, 1);
        tbl[18] = mk(1, 1, 32'h77777777, 32'h13002130, 4'b1011, 0, 1, 0);
        tbl[19] = mk(0, 0, 32'h00000000, 32'h00223100, 4'b0110, 0, 1, 0);
        tbl[20] = mk(0, 0, 32'h00000000, 32'h23320000, 4'b1100, 0, 1, 0);
        tbl[21] = mk(0, 0, 32'h00000000, 32'h33000000, 4'b1000, 1, 1, 0);
        tbl[22] = mk(0, 0, 32'h00000000, 32'h00000000, 4'b0000, 0, 0, 0);

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_a_out", 0, a_out, 32'h0);
        chk("rst_out_valid", 0, 32'(out_valid), 32'h0);
        chk("rst_busy", 0, 32'(busy), 32'h0);
        chk("rst_done", 0, 32'(done), 32'h0);
        chk("rst_in_ready", 0, 32'(in_ready), 32'h0);
        rst = 1'b0;

        // DIM=1: beat accepted at T shows with done in T+1
        @(negedge clk);
        start1 = 1'b1;
        #1 chk("d1_ready_idle", 1, 32'(in_ready1), 32'h0);
        @(negedge clk);
        start1 = 1'b0; in_valid1 = 1'b1; a_in1 = 8'hAB; b_in1 = 8'hCD;
        #1 chk("d1_ready_feed", 2, 32'(in_ready1), 32'h1);
        chk("d1_valid_feed", 2, 32'(out_valid1), 32'h0);
        @(negedge clk);
        in_valid1 = 1'b0; a_in1 = 8'h00; b_in1 = 8'h00;
        #1 chk("d1_a_out", 3, 32'(a_out1), 32'hAB);
        chk("d1_b_out", 3, 32'(b_out1), 32'hCD);
        chk("d1_valid", 3, 32'(out_valid1), 32'h1);
        chk("d1_done", 3, 32'(done1), 32'h1);
        chk("d1_busy", 3, 32'(busy1), 32'h1);
        chk("d1_ready_drain", 3, 32'(in_ready1), 32'h0);
        @(negedge clk);
        #1 chk("d1_valid_after", 4, 32'(out_valid1), 32'h0);
        chk("d1_done_after", 4, 32'(done1), 32'h0);
        chk("d1_busy_after", 4, 32'(busy1), 32'h0);
        chk("d1_a_after", 4, 32'(a_out1), 32'h0);

        // table: idle guard, basic pass, bubble pass
        apply_range(0, 22, 100);

        // back-to-back: start held through the done cycle and the next one
        apply_range(2, 9, 200);
        apply(mk(1, 0, 32'h0, 32'h33000000, 4'b1000, 1, 1, 0), 250);
        apply(mk(1, 0, 32'h0, 32'h00000000, 4'b0000, 0, 0, 0), 251);
        apply_range(3, 11, 300);

        // reset mid-pass after beat 2 accepted
        apply_range(2, 5, 400);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; a_in = 32'h33323130; b_in = 32'hB3B2B1B0;
        #2 rst = 1'b1;
        #1 chk("mid_rst_a_out", 450, a_out, 32'h0);
        chk("mid_rst_b_out", 450, b_out, 32'h0);
        chk("mid_rst_valid", 450, 32'(out_valid), 32'h0);
        chk("mid_rst_busy", 450, 32'(busy), 32'h0);
        chk("mid_rst_ready", 450, 32'(in_ready), 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1 chk("mid_rst_done", 460 + c, 32'(done), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
        #1 chk("post_rst_done", 470, 32'(done), 32'h0);
        chk("post_rst_valid", 470, 32'(out_valid), 32'h0);
        apply_range(2, 11, 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream feeder for the DIM x DIM systolic array driven by systolic_ctrl.
- Accepts one unskewed A column vector and one unskewed B row vector per beat, for DIM beats.
- Emits diagonally staggered lane streams: lane i is delayed by i cycles, so operands meet in the correct PE.
- Frames each matrix pass with start/busy/done so the controller can align its count window.

Parameters:
DIM, 4, array dimension; lanes per operand and beats per pass; must be >= 1
DATA_W, 8, operand width per lane, in bits

Ports:
clk  in  1  clock, rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE
in_valid  in  1  a_in/b_in hold a beat
in_ready  out  1  feeder accepts a beat; combinational, high only in FEED
a_in  in  DIM*DATA_W  lane i = A[i][k] for beat k; lane i occupies bits [i*DATA_W +: DATA_W]
b_in  in  DIM*DATA_W  lane j = B[k][j] for beat k; same packing
a_out  out  DIM*DATA_W  skewed A lanes to array west edge
b_out  out  DIM*DATA_W  skewed B lanes to array north edge
out_valid  out  DIM  per-lane valid, bit i qualifies lane i of both a_out and b_out
busy  out  1  high in FEED and DRAIN
done  out  1  one-cycle pulse at pass completion

Behaviour:
- Reset: asynchronous, active-high, applies immediately. All outputs go to 0 and all skew registers clear. State goes to IDLE and counters go to 0. Reset mid-pass abandons the pass; no done pulse is produced.
- FSM has three states:
  - IDLE: start=1 at an edge moves to FEED. in_valid is ignored.
  - FEED: in_ready=1. A beat is accepted on an edge where in_valid=1. The beat counter, width clog2(DIM+1), counts accepted beats. The edge that accepts beat DIM-1 moves to DRAIN.
  - DRAIN: lasts exactly DIM cycles, with in_ready=0. At the end of the last DRAIN cycle, move to IDLE.
- start is ignored while busy=1.
- Skew datapath:
  - Lane i of each operand passes through a shift chain of i+1 registers.
  - Each register carries data plus a valid bit.
  - If beat k is accepted at edge T, lane i of that beat appears on a_out/b_out with out_valid[i]=1 during cycle T+1+i.
- Bubbles: a FEED cycle with in_valid=0 injects a bubble, i.e. data 0 with valid 0, into every lane chain. Bubbles keep their relative skew. No data is ever dropped or duplicated.
- Invalid lanes always drive data 0, never stale values.
- Timing of the last beat, accepted at edge T:
  - DRAIN covers cycles T+1 .. T+DIM.
  - done=1 and busy=1 for exactly cycle T+DIM, which is also the cycle where lane DIM-1 shows its last valid.
  - busy=0 from T+DIM+1.
- DIM=1: there is no skew. Output appears at T+1 together with done.
- Back-to-back passes: start may be asserted in the cycle done is high. It is sampled in IDLE at the next edge.
- No arithmetic is performed on the data. Widths pass through unchanged.

Test Plan (DIM=4, DATA_W=8):
- Basic pass: start, then 4 consecutive beats with a_in lane i = 0x10*k+i (k = 0..3).
  - a_out lane i shows 0x10*k+i in cycle T0+1+k+i.
  - out_valid follows the staircase 0001, 0011, 0111, 1111, 1110, 1100, 1000.
  - done is high in cycle T0+7 only.
- Bubble: the same pass with in_valid=0 for one cycle between beats 1 and 2.
  - A zero/invalid diagonal appears in every lane.
  - Beats 2 and 3 are shifted by 1 cycle.
  - done is delayed by 1 cycle; 4 valids per lane in total.
- Handshake guards:
  - in_valid=1 in IDLE gives in_ready=0 and no output valid.
  - start pulsed during FEED and DRAIN is ignored.
  - in_ready=0 during all 4 DRAIN cycles.
- Reset mid-pass: assert rst after beat 2 is accepted. All outputs go to 0 asynchronously. No done pulse. A fresh pass afterwards behaves exactly as in the basic pass.
- Back-to-back: assert start in the cycle done=1. The second pass in_ready rises 2 cycles after the first done. Outputs of the two passes do not overlap or corrupt each other.
- DIM=1 instance: a single beat 0xAB accepted at T gives a_out=0xAB, out_valid=1 and done=1 in cycle T+1.
